// File: rtl/debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The optional input synchronizer is selected with BUTTON_DEBOUNCER_SYNC_EN.
package debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_W         = 24;

  // True when the terminal count STABLE_CYCLES-1 is representable in w bits.
  function automatic bit cnt_fits(input int stable, input int w);
    return (stable >= 2) && (w >= 1) && (w <= 31) && ((stable - 1) < (1 << w));
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw level in, debounced level and press strobe out.
interface button_debouncer_if;
  logic btn_in;
  logic dato;
  logic pulse;

  modport master (output btn_in, input dato, input pulse);
  modport slave  (input btn_in, output dato, output pulse);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous button level; both flops clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta_p0;
  logic r_sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_meta_p0 <= d;
      r_sync_p1 <= r_meta_p0;
    end
  end

  assign q = r_sync_p1;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: a level is accepted after STABLE_CYCLES+1 consecutive equal samples.
// Define BUTTON_DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer (+2 cycles latency).
module button_debouncer
  import debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  button_debouncer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  if (!cnt_fits(STABLE_CYCLES, CNT_W)) begin : g_bad_param
    $error("button_debouncer: STABLE_CYCLES-1 does not fit in CNT_W bits");
  end

  logic w_s;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (w_s)
  );
`else
  assign w_s = bus.btn_in;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dato;
  logic             r_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_dato  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          // Any low sample aborts; qualification restarts from IDLE_LOW.
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_dato  <= 1'b1;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dato  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_dato  <= 1'b0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dato  = r_dato;
  assign bus.pulse = r_pulse;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with STABLE_CYCLES=4: vector table, corner sequences, random vs model.
module tb_button_debouncer;

  localparam int N = 4;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  button_debouncer_if bif ();

  button_debouncer #(.STABLE_CYCLES(N), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: run length of samples opposite to the accepted level.
  bit m_dato, m_pulse, m_sync0, m_sync1;
  int m_run;

  typedef struct {
    bit rst;
    bit btn;
    bit dato;
    bit pulse;
  } vec_t;

  vec_t tbl[44];

  task automatic check(input string name, input logic act, input bit exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit b);
    bit s;
    rst = r;
    bif.btn_in = b;
    @(posedge clk);
    if (r) begin
      m_dato = 1'b0; m_pulse = 1'b0; m_run = 0;
      m_sync0 = 1'b0; m_sync1 = 1'b0;
    end else begin
      s = (LAT == 2) ? m_sync1 : b;
      m_sync1 = m_sync0;
      m_sync0 = b;
      m_pulse = 1'b0;
      if (s != m_dato) begin
        m_run++;
        if (m_run == N + 1) begin
          m_dato  = s;
          m_pulse = s;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  initial begin
    bit cur;
    int left;
    int pulses;
    rst = 1'b1;
    bif.btn_in = 1'b0;

    tbl = '{
      '{1,1,0,0}, '{1,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0},
      '{0,1,1,1}, '{0,1,1,0}, '{0,1,1,0},
      '{0,0,1,0}, '{0,0,1,0}, '{0,0,1,0}, '{0,1,1,0},
      '{0,0,1,0}, '{0,0,1,0}, '{0,0,1,0}, '{0,0,1,0}, '{0,0,0,0},
      '{0,1,0,0}, '{0,1,0,0}, '{0,0,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0},
      '{0,1,0,0}, '{0,1,1,1}, '{0,1,1,0},
      '{0,0,1,0}, '{0,0,1,0}, '{0,0,1,0}, '{0,0,1,0}, '{0,0,0,0},
      '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{1,1,0,0},
      '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,1,1,1}, '{0,1,1,0},
      '{1,1,0,0}, '{0,0,0,0}
    };

    // Cycle-exact table for the direct-sampling build.
`ifndef BUTTON_DEBOUNCER_SYNC_EN
    for (int i = 0; i < 44; i++) begin
      step(tbl[i].rst, tbl[i].btn);
      check($sformatf("tbl%0d_dato", i), bif.dato, tbl[i].dato);
      check($sformatf("tbl%0d_pulse", i), bif.pulse, tbl[i].pulse);
    end
`endif

    // Reset on the edge that would have completed qualification: no pulse.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < N + LAT; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("midq_rst_dato", bif.dato, 1'b0);
    check("midq_rst_pulse", bif.pulse, 1'b0);

    // Re-qualification after reset with the button already held; one pulse only.
    pulses = 0;
    for (int k = 0; k < N + LAT + 8; k++) begin
      step(1'b0, 1'b1);
      check($sformatf("press_k%0d_dato", k), bif.dato, k >= N + LAT);
      check($sformatf("press_k%0d_pulse", k), bif.pulse, k == N + LAT);
      if (bif.pulse === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL press_pulse_count: got %0d, expected 1", pulses);
    end

    // Release with no rising strobe.
    for (int k = 0; k < N + LAT + 3; k++) begin
      step(1'b0, 1'b0);
      check($sformatf("rel_k%0d_dato", k), bif.dato, k < N + LAT);
      check($sformatf("rel_k%0d_pulse", k), bif.pulse, 1'b0);
    end

    // Random bouncing runs with occasional resets, checked against the model.
    cur = 1'b0;
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        cur  = ~cur;
        left = $urandom_range(1, 2 * N + 3);
      end
      left--;
      step(($urandom_range(0, 199) == 0), cur);
      check($sformatf("rnd%0d_dato", i), bif.dato, m_dato);
      check($sformatf("rnd%0d_pulse", i), bif.pulse, m_pulse);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
